// File: rtl/dtpu_pkg.sv
// Shared definitions for the matrix-unit job sequencer.
//   seq_state_t : sequencer FSM state encoding
//   CSR_*       : byte offsets of the job configuration in CSR memory
//   mxu_mode_t  : MXU precision encodings driven on mxu_mode
package dtpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_LOAD_W,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] CSR_MODE    = 2'd0;
  localparam logic [1:0] CSR_NVEC_LO = 2'd1;
  localparam logic [1:0] CSR_NVEC_HI = 2'd2;

  typedef enum logic [1:0] {
    MODE_8B  = 2'd0,
    MODE_16B = 2'd1,
    MODE_32B = 2'd2,
    MODE_64B = 2'd3
  } mxu_mode_t;

endpackage

// File: rtl/mxu_valid_pipe.sv
// Valid-bit shadow of the MXU datapath pipeline.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous flush, used when a new job is accepted
//   advance    : shift enable (pipeline moves only when the MXU advances)
//   valid_in   : valid bit entering stage 0 (1 = real vector, 0 = bubble)
//   tail       : valid bit of the last stage; its result is writable now
module mxu_valid_pipe #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  input  logic valid_in,
  output logic tail
);

  logic [LATENCY-1:0] stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else if (clear) begin
      stage <= '0;
    end else if (advance) begin
      stage[0] <= valid_in;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tail = stage[LATENCY-1];

endmodule

// File: rtl/mxu_job_sequencer.sv
// Matrix-unit job sequencer: one job per accepted cs_start.
//   clk, reset            : clock, async active-high reset
//   enable_mxu, mxu_mode  : MXU pipeline advance and precision
//   csr_*                 : job configuration reads (mode, n_vec lo/hi)
//   wm_*                  : weight row preload, addresses 0..MXU_ROWS-1
//   infifo_*, outfifo_*   : vector stream in/out with independent stalls
//   cs_*                  : PS handshake start/ready/idle/done/continue
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cs_start, ready/idle asserted
// ST_CFG    | three CSR reads, data captured one cycle after each read
// ST_LOAD_W | one weight row per cycle for MXU_ROWS cycles
// ST_RUN    | stream n_vec vectors through the MXU pipeline
// ST_DONE   | cs_done held until cs_continue
module mxu_job_sequencer
  import dtpu_pkg::*;
#(
  parameter int MXU_ROWS             = 8,
  parameter int MXU_LATENCY          = 4,
  parameter int CNT_WIDTH            = 16,
  parameter int DATA_WIDTH_CSR       = 8,
  parameter int ADDRESS_SIZE_CSR     = 32,
  parameter int ADDRESS_SIZE_WMEMORY = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            enable_mxu,
  output logic [1:0]                      mxu_mode,
  output logic                            csr_ce,
  output logic                            csr_we,
  output logic [ADDRESS_SIZE_CSR-1:0]     csr_address,
  input  logic [DATA_WIDTH_CSR-1:0]       csr_dout,
  output logic                            wm_ce,
  output logic                            wm_we,
  output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address,
  input  logic                            infifo_is_empty,
  output logic                            infifo_read,
  input  logic                            outfifo_is_full,
  output logic                            outfifo_write,
  input  logic                            cs_start,
  output logic                            cs_ready,
  output logic                            cs_idle,
  output logic                            cs_done,
  input  logic                            cs_continue
);

  localparam int WC_W = (MXU_ROWS > 1) ? $clog2(MXU_ROWS) : 1;

  seq_state_t           state, state_nxt;
  logic [1:0]           cfg_cnt;
  logic [1:0]           cap_sel;
  logic [WC_W-1:0]      w_cnt;
  logic [15:0]          n_vec_raw;
  logic [CNT_WIDTH-1:0] n_vec, issued, retired;
  mxu_mode_t            mode;
  logic                 job_accept;
  logic                 pipe_tail;

  assign n_vec      = CNT_WIDTH'(n_vec_raw);
  assign job_accept = (state == ST_IDLE) && cs_start;
  // CSR data arriving this cycle belongs to the read issued last cycle.
  assign cap_sel    = cfg_cnt - 2'd1;
  assign mxu_mode   = mode;
  assign csr_we     = 1'b0;
  assign wm_we      = 1'b0;

  always_comb begin
    state_nxt     = state;
    enable_mxu    = 1'b0;
    infifo_read   = 1'b0;
    outfifo_write = 1'b0;
    csr_ce        = 1'b0;
    csr_address   = '0;
    wm_ce         = 1'b0;
    wm_address    = '0;
    cs_ready      = 1'b0;
    cs_idle       = 1'b0;
    cs_done       = 1'b0;
    case (state)
      ST_IDLE: begin
        cs_ready = 1'b1;
        cs_idle  = 1'b1;
        if (cs_start) state_nxt = ST_CFG;
      end
      ST_CFG: begin
        csr_ce      = (cfg_cnt != 2'd3);
        csr_address = ADDRESS_SIZE_CSR'(cfg_cnt);
        if (cfg_cnt == 2'd3) state_nxt = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        wm_ce      = 1'b1;
        wm_address = ADDRESS_SIZE_WMEMORY'(w_cnt);
        if (w_cnt == WC_W'(MXU_ROWS - 1))
          state_nxt = (n_vec == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // A full output FIFO freezes the whole pipe; an empty input FIFO
        // only turns the inserted slot into a bubble.
        enable_mxu    = !outfifo_is_full;
        infifo_read   = enable_mxu && !infifo_is_empty && (issued < n_vec);
        outfifo_write = enable_mxu && pipe_tail;
        if ((retired == n_vec) ||
            (outfifo_write && ((retired + CNT_WIDTH'(1)) == n_vec)))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cs_done = 1'b1;
        if (cs_continue) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cfg_cnt   <= '0;
      w_cnt     <= '0;
      n_vec_raw <= '0;
      mode      <= MODE_8B;
      issued    <= '0;
      retired   <= '0;
    end else begin
      state <= state_nxt;
      if (job_accept) begin
        cfg_cnt <= '0;
        w_cnt   <= '0;
        issued  <= '0;
        retired <= '0;
      end
      if (state == ST_CFG) begin
        cfg_cnt <= cfg_cnt + 2'd1;
        case (cap_sel)
          CSR_MODE:    mode            <= mxu_mode_t'(csr_dout[1:0]);
          CSR_NVEC_LO: n_vec_raw[7:0]  <= csr_dout[7:0];
          CSR_NVEC_HI: n_vec_raw[15:8] <= csr_dout[7:0];
          default: ;
        endcase
      end
      if (state == ST_LOAD_W) w_cnt <= w_cnt + WC_W'(1);
      if (infifo_read)   issued  <= issued + CNT_WIDTH'(1);
      if (outfifo_write) retired <= retired + CNT_WIDTH'(1);
    end
  end

  mxu_valid_pipe #(
    .LATENCY (MXU_LATENCY)
  ) u_valid_pipe (
    .clk      (clk),
    .reset    (reset),
    .clear    (job_accept),
    .advance  (enable_mxu),
    .valid_in (infifo_read),
    .tail     (pipe_tail)
  );

endmodule

// File: tb/tb_mxu_job_sequencer.sv
module tb_mxu_job_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_mxu;
  logic [1:0]  mxu_mode;
  logic        csr_ce, csr_we;
  logic [31:0] csr_address;
  logic [7:0]  csr_dout;
  logic        wm_ce, wm_we;
  logic [31:0] wm_address;
  logic        infifo_is_empty, infifo_read;
  logic        outfifo_is_full, outfifo_write;
  logic        cs_start, cs_ready, cs_idle, cs_done, cs_continue;

  always #5 clk = ~clk;

  mxu_job_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .enable_mxu      (enable_mxu),
    .mxu_mode        (mxu_mode),
    .csr_ce          (csr_ce),
    .csr_we          (csr_we),
    .csr_address     (csr_address),
    .csr_dout        (csr_dout),
    .wm_ce           (wm_ce),
    .wm_we           (wm_we),
    .wm_address      (wm_address),
    .infifo_is_empty (infifo_is_empty),
    .infifo_read     (infifo_read),
    .outfifo_is_full (outfifo_is_full),
    .outfifo_write   (outfifo_write),
    .cs_start        (cs_start),
    .cs_ready        (cs_ready),
    .cs_idle         (cs_idle),
    .cs_done         (cs_done),
    .cs_continue     (cs_continue)
  );

  int         n_cmp, n_err;
  int         cyc, start_cyc, rel;
  int         rd_cnt, wr_cnt, wm_n, csr_n, en_cnt, full_quiet, first_rd, done_cyc;
  int         wr_cyc [16];
  logic [31:0] wm_log [16];
  logic [1:0]  csr_log [4];
  logic [7:0]  csr_mem [4];
  logic        ce_s;
  logic [1:0]  ad_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_cnt = 0; wr_cnt = 0; wm_n = 0; csr_n = 0; en_cnt = 0;
    full_quiet = 0; first_rd = -1; done_cyc = -1;
    for (int i = 0; i < 16; i++) wr_cyc[i] = -1;
  endtask

  // Observe at the falling edge, then act as the CSR memory at the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      if (infifo_read) begin
        if (first_rd < 0) first_rd = cyc;
        rd_cnt++;
        chk("rd_while_empty", infifo_is_empty, 0);
      end
      if (outfifo_write) begin
        if (wr_cnt < 16) wr_cyc[wr_cnt] = cyc;
        wr_cnt++;
        chk("wr_while_full", outfifo_is_full, 0);
      end
      if (enable_mxu) en_cnt++;
      if (outfifo_is_full && !enable_mxu && !infifo_read && !outfifo_write) full_quiet++;
      if (wm_ce) begin
        if (wm_n < 16) wm_log[wm_n] = wm_address;
        wm_n++;
      end
      if (csr_ce) begin
        if (csr_n < 4) csr_log[csr_n] = csr_address[1:0];
        csr_n++;
      end
      if (cs_done && done_cyc < 0) done_cyc = cyc;
    end
    ce_s = csr_ce;
    ad_s = csr_address[1:0];
    @(posedge clk);
    #1;
    if (ce_s) csr_dout = csr_mem[ad_s];
    cyc++;
  endtask

  task automatic run_job(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int ff, input int fl, input int ef, input int el, input int budget);
    csr_mem[0] = b0; csr_mem[1] = b1; csr_mem[2] = b2;
    clear_log();
    cs_start = 1'b1;
    start_cyc = cyc;
    tick();
    cs_start = 1'b0;
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      rel = cyc - start_cyc;
      outfifo_is_full = (rel >= ff) && (rel < ff + fl);
      infifo_is_empty = (rel >= ef) && (rel < ef + el);
      tick();
    end
    outfifo_is_full = 1'b0;
    infifo_is_empty = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
  endtask

  task automatic ack();
    cs_continue = 1'b1;
    cs_start    = 1'b1;
    tick();
    cs_continue = 1'b0;
    chk("ack_idle", cs_idle, 1);
    chk("ack_start_ignored", csr_ce, 0);
    cs_start = 1'b0;
    tick();
    chk("idle_stays", cs_idle, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    reset = 1'b1; cs_start = 1'b0; cs_continue = 1'b0;
    infifo_is_empty = 1'b0; outfifo_is_full = 1'b0; csr_dout = 8'h00;
    for (int i = 0; i < 4; i++) csr_mem[i] = 8'h00;
    clear_log();
    tick(); tick();
    chk("rst_ready", cs_ready, 1);
    chk("rst_idle", cs_idle, 1);
    chk("rst_done", cs_done, 0);
    chk("rst_strobes", {enable_mxu, csr_ce, csr_we, wm_ce, wm_we, infifo_read, outfifo_write}, 0);
    chk("rst_mode", mxu_mode, 0);
    reset = 1'b0;
    tick();

    // Basic job: mode 2, five vectors, no stalls.
    run_job(8'h02, 8'h05, 8'h00, 1000, 0, 1000, 0, 100);
    chk("a_done_cycle", done_cyc - start_cyc, 22);
    chk("a_mode", mxu_mode, 2);
    chk("a_csr_reads", csr_n, 3);
    for (int i = 0; i < 3; i++) chk("a_csr_addr", csr_log[i], i);
    chk("a_wm_rows", wm_n, 8);
    for (int i = 0; i < 8; i++) chk("a_wm_addr", wm_log[i], i);
    chk("a_reads", rd_cnt, 5);
    chk("a_writes", wr_cnt, 5);
    chk("a_first_read", first_rd - start_cyc, 13);
    chk("a_latency", wr_cyc[0] - first_rd, 4);
    chk("a_done_hold", cs_done, 1);
    chk("a_done_not_ready", cs_ready, 0);
    chk("a_done_mxu_off", enable_mxu, 0);
    ack();

    // Output FIFO full for 3 cycles while reading.
    run_job(8'h02, 8'h05, 8'h00, 15, 3, 1000, 0, 100);
    chk("b_full_quiet", full_quiet, 3);
    chk("b_reads", rd_cnt, 5);
    chk("b_writes", wr_cnt, 5);
    chk("b_done_cycle", done_cyc - start_cyc, 25);
    ack();

    // Input FIFO empty for 2 cycles after the second read.
    run_job(8'h02, 8'h05, 8'h00, 1000, 0, 15, 2, 100);
    chk("c_reads", rd_cnt, 5);
    chk("c_writes", wr_cnt, 5);
    chk("c_wr_back2back", wr_cyc[1] - wr_cyc[0], 1);
    chk("c_wr_gap", wr_cyc[2] - wr_cyc[1], 3);
    chk("c_done_cycle", done_cyc - start_cyc, 24);
    ack();

    // Zero vectors: straight from LOAD_W to DONE.
    run_job(8'h01, 8'h00, 8'h00, 1000, 0, 1000, 0, 100);
    chk("d_done_cycle", done_cyc - start_cyc, 13);
    chk("d_reads", rd_cnt, 0);
    chk("d_writes", wr_cnt, 0);
    chk("d_enable", en_cnt, 0);
    chk("d_wm_rows", wm_n, 8);
    chk("d_mode", mxu_mode, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("d_done_held", cs_done, 1);
    end
    ack();

    // Full and empty together at the last vector; full released first.
    run_job(8'h00, 8'h04, 8'h00, 16, 3, 16, 5, 100);
    chk("e_reads", rd_cnt, 4);
    chk("e_writes", wr_cnt, 4);
    chk("e_first_wr", wr_cyc[0] - start_cyc, 20);
    chk("e_last_wr", wr_cyc[3] - start_cyc, 25);
    chk("e_done_cycle", done_cyc - start_cyc, 26);
    chk("e_mode", mxu_mode, 0);
    ack();

    // Reset in the middle of RUN after three reads.
    csr_mem[0] = 8'h00; csr_mem[1] = 8'h0A; csr_mem[2] = 8'h00;
    clear_log();
    cs_start = 1'b1;
    tick();
    cs_start = 1'b0;
    for (int i = 0; i < 40 && rd_cnt < 3; i++) tick();
    chk("f_three_issued", rd_cnt, 3);
    chk("f_running", infifo_read, 1);
    reset = 1'b1;
    #1;
    chk("f_rst_strobes", {enable_mxu, csr_ce, wm_ce, infifo_read, outfifo_write}, 0);
    chk("f_rst_idle", cs_idle, 1);
    chk("f_rst_ready", cs_ready, 1);
    chk("f_rst_done", cs_done, 0);
    tick();
    reset = 1'b0;
    tick();
    run_job(8'hFF, 8'h02, 8'h00, 1000, 0, 1000, 0, 100);
    chk("f_csr_reload", csr_n, 3);
    chk("f_mode", mxu_mode, 3);
    chk("f_reads", rd_cnt, 2);
    chk("f_writes", wr_cnt, 2);
    chk("f_done_cycle", done_cyc - start_cyc, 19);
    ack();

    // High byte of n_vec in use: 0x0103 = 259 vectors.
    run_job(8'h01, 8'h03, 8'h01, 1000, 0, 1000, 0, 400);
    chk("g_reads", rd_cnt, 259);
    chk("g_writes", wr_cnt, 259);
    chk("g_done_cycle", done_cyc - start_cyc, 276);
    chk("g_mode", mxu_mode, 1);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mxu_job_sequencer.md
Name: mxu_job_sequencer

Overview:
Parametrised successor to the DTPU control unit.
- Runs one matrix-unit job per `cs_start`:
  - fetches job configuration from the CSR memory;
  - preloads MXU_ROWS weight rows from weight memory;
  - streams a configurable number of input vectors from the input FIFO through an MXU pipeline of configurable latency into the output FIFO.
- Handles stalls independently on both FIFOs. Handshakes with the PS via start/ready/idle/done/continue.

Parameters:
MXU_ROWS, 8, weight rows loaded per job (wm addresses 0..MXU_ROWS-1)
MXU_LATENCY, 4, cycles from infifo_read to the matching result being writable (>=1)
CNT_WIDTH, 16, width of the vector counters
DATA_WIDTH_CSR, 8, CSR read data width
ADDRESS_SIZE_CSR, 32, CSR address width
ADDRESS_SIZE_WMEMORY, 32, weight memory address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; all state cleared immediately
enable_mxu  out  1  MXU pipeline advance enable
mxu_mode  out  2  precision: 0=8b, 1=16b, 2=32b, 3=64b
csr_ce  out  1  CSR read enable
csr_we  out  1  CSR write enable, tied 0
csr_address  out  ADDRESS_SIZE_CSR  CSR read address
csr_dout  in  DATA_WIDTH_CSR  CSR read data, valid one cycle after csr_ce
wm_ce  out  1  weight memory enable
wm_we  out  1  tied 0
wm_address  out  ADDRESS_SIZE_WMEMORY  weight row address
infifo_is_empty  in  1  input FIFO empty
infifo_read  out  1  pop input FIFO
outfifo_is_full  in  1  output FIFO full
outfifo_write  out  1  push output FIFO
cs_start  in  1  job request, level
cs_ready  out  1  can accept start
cs_idle  out  1  sequencer idle
cs_done  out  1  job complete, held until acknowledged
cs_continue  in  1  done acknowledge

Behaviour:
- Reset values: all outputs 0 except cs_ready=1 and cs_idle=1. State is IDLE; counters, mode, n_vec and the valid pipe are cleared.
- Reset asserted mid-job: return to IDLE immediately. No further FIFO or memory strobes are issued.
- IDLE:
  - cs_ready=cs_idle=1.
  - cs_start=1 -> CFG next cycle.
  - cs_start is ignored in every other state.
- CFG: three reads at addresses 0, 1, 2 on consecutive cycles (csr_ce=1). Data is captured one cycle after each read:
  - byte0[1:0] -> mode;
  - byte1 -> n_vec[7:0];
  - byte2 -> n_vec[15:8] (bits above CNT_WIDTH-1 are dropped).
  - After the last capture (4 cycles in CFG) -> LOAD_W.
- LOAD_W:
  - wm_ce=1, wm_address counts 0..MXU_ROWS-1, one per cycle, giving exactly MXU_ROWS cycles.
  - Then -> RUN, or -> DONE if n_vec==0.
- RUN:
  - enable_mxu = !outfifo_is_full.
  - infifo_read = enable_mxu && !infifo_is_empty && issued<n_vec.
  - The valid pipe (MXU_LATENCY bits) shifts only when enable_mxu. It inserts infifo_read, or a bubble when the FIFO is empty.
  - outfifo_write = enable_mxu && pipe tail valid.
  - issued increments on infifo_read; retired increments on outfifo_write.
  - Output-full freezes the whole pipe: no read, no write, no shift.
  - Input-empty inserts bubbles only.
  - retired==n_vec -> DONE.
- DONE:
  - cs_done=1, enable_mxu=0.
  - cs_continue=1 -> IDLE next cycle.
  - cs_start seen in the same cycle is not accepted until IDLE.
- mxu_mode holds the captured mode from CFG until the next CFG.
- No read is ever issued when empty; no write is ever issued when full.
- Latency with FIFOs never stalling: first outfifo_write occurs MXU_LATENCY cycles after the first infifo_read.
- Total cycles start->done = 4 + MXU_ROWS + n_vec + MXU_LATENCY + 1.

Decomposition:
- Shared package dtpu_pkg:
  - state encoding (IDLE, CFG, LOAD_W, RUN, DONE);
  - CSR offsets (CSR_MODE=0, CSR_NVEC_LO=1, CSR_NVEC_HI=2);
  - mode encodings.
- One sub-module: mxu_valid_pipe, a MXU_LATENCY-deep enable-gated valid shift register with an occupancy-free tail output.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-RUN (n_vec=10, 3 issued), reset pulse -> all strobes 0 in the same cycle, cs_idle=1, cs_ready=1; a new start reloads the CSR.
- CSR bytes {0x02,0x05,0x00}, MXU_ROWS=8, LATENCY=4, FIFOs never stall -> mxu_mode=2; wm addresses 0..7; 5 reads, then 5 writes starting 4 cycles after the first read; cs_done at cycle 4+8+5+4+1=22.
- outfifo_is_full high for 3 cycles during RUN -> enable_mxu, infifo_read and outfifo_write all 0 for those 3 cycles; 5 writes still delivered, done delayed by 3.
- infifo_is_empty high for 2 cycles after the 2nd read -> 2 bubbles, no read while empty; write count=5, gap of 2 in the write stream.
- n_vec=0 -> after LOAD_W goes straight to DONE, zero FIFO strobes. cs_continue held low 5 cycles keeps cs_done=1; continue=1 -> IDLE next cycle.
- Simultaneous full and empty at the last vector, released in opposite order -> exactly n_vec writes, retired==issued==n_vec at DONE.
